// File: rtl/ahb_addr_decoder.sv
// rtl/ahb_addr_decoder.sv - AHB-Lite address decoder with integrated default slave
// Ports: HCLK/HRESET clock and synchronous active-high reset; HADDR/HTRANS/HREADY address-phase
// inputs; HSEL one-hot combinational slave select; MUX_SEL registered data-phase select
// (SLAVE_NUM selects the default slave); HREADYOUT_DEF/HRESP_DEF default slave response;
// ERR_COUNT saturating count of unmapped accesses, present only with AHB_DECODER_ERRCNT_EN.
module ahb_addr_decoder #(
    parameter int SLAVE_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MAP_BITS   = 4,
    parameter int SEL_W      = $clog2(SLAVE_NUM + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [SLAVE_NUM-1:0]  HSEL,
    output logic [SEL_W-1:0]      MUX_SEL,
    output logic                  HREADYOUT_DEF,
    output logic                  HRESP_DEF,
    output logic [15:0]           ERR_COUNT
);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    localparam logic [MAP_BITS-1:0] REGION_LIMIT = MAP_BITS'(SLAVE_NUM);
    localparam logic [SEL_W-1:0]    SEL_DEF      = SEL_W'(SLAVE_NUM);

    ds_state_t           state;
    ds_state_t           state_next;
    logic [MAP_BITS-1:0] region;
    logic                def_sel;
    logic                err_start;
    logic                unused_bits;

    assign region    = HADDR[ADDR_WIDTH-1 -: MAP_BITS];
    assign def_sel   = (region >= REGION_LIMIT);
    // Only an accepted NONSEQ/SEQ to an unmapped region earns an ERROR; IDLE/BUSY get OKAY.
    assign err_start = HREADY & def_sel & HTRANS[1];

    // Lower address bits and HTRANS[0] do not take part in decoding.
    assign unused_bits = ^{HADDR[ADDR_WIDTH-MAP_BITS-1:0], HTRANS[0]};

    always_comb begin
        HSEL = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            HSEL[i] = (region == MAP_BITS'(i));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= DS_IDLE;
            MUX_SEL <= SEL_DEF;
        end else begin
            state <= state_next;
            // Held across wait states so the response mux stays on the active slave.
            if (HREADY) begin
                MUX_SEL <= def_sel ? SEL_DEF : SEL_W'(region);
            end
        end
    end

    always_comb begin
        state_next    = state;
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = 1'b0;
        case (state)
            DS_IDLE: begin
                if (err_start) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                // Our own HREADYOUT_DEF=0 is the bus HREADY here, so no sampling is needed.
                HREADYOUT_DEF = 1'b0;
                HRESP_DEF     = 1'b1;
                state_next    = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP_DEF  = 1'b1;
                state_next = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

`ifdef AHB_DECODER_ERRCNT_EN
    logic [15:0] err_count;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_count <= 16'h0000;
        end else if ((state_next == DS_ERR1) && (state != DS_ERR1) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end

    assign ERR_COUNT = err_count;
`else
    assign ERR_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// tb/tb_ahb_addr_decoder.sv - scoreboard bench for ahb_addr_decoder
module tb_ahb_addr_decoder;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
`ifdef AHB_DECODER_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  sel;
        logic        rdy;
        logic        resp;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        ready;
        logic [3:0]  hsel;
        obs_t        exp;
    } stim_t;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [3:0]  HSEL;
    logic [2:0]  MUX_SEL;
    logic        HREADYOUT_DEF;
    logic        HRESP_DEF;
    logic [15:0] ERR_COUNT;

    int   errors;
    int   checks;
    obs_t sb[$];

    ahb_addr_decoder #(
        .SLAVE_NUM (4),
        .ADDR_WIDTH(32),
        .MAP_BITS  (4)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HREADY       (HREADY),
        .HSEL         (HSEL),
        .MUX_SEL      (MUX_SEL),
        .HREADYOUT_DEF(HREADYOUT_DEF),
        .HRESP_DEF    (HRESP_DEF),
        .ERR_COUNT    (ERR_COUNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input logic rst, input logic [31:0] addr, input logic [1:0] trans,
                                 input logic ready, input logic [3:0] hsel, input logic [2:0] sel,
                                 input logic rdy, input logic resp, input int n);
        stim_t s;
        s.rst   = rst;
        s.addr  = addr;
        s.trans = trans;
        s.ready = ready;
        s.hsel  = hsel;
        s.exp   = '{sel: sel, rdy: rdy, resp: resp, cnt: (CNT_EN ? 16'(n) : 16'h0000)};
        return s;
    endfunction

    task automatic test_reset();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(1, 32'h3000_0000, NONSEQ, 1, 4'b1000, 3'd4, 1, 0, 0));
        st.push_back(mk(1, 32'h3000_0000, NONSEQ, 1, 4'b1000, 3'd4, 1, 0, 0));
        st.push_back(mk(0, 32'h3000_0000, IDLE,   1, 4'b1000, 3'd3, 1, 0, 0));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL reset_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_sweep();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        for (int i = 0; i < 4; i++) begin
            st.push_back(mk(0, 32'(i) << 28, NONSEQ, 1, 4'(1 << i), 3'(i), 1, 0, 0));
        end
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL sweep_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sweep_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_unmapped();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(0, 32'h5000_0000, NONSEQ, 1, 4'b0000, 3'd4, 0, 1, 1));
        st.push_back(mk(0, 32'h0000_0000, IDLE,   0, 4'b0001, 3'd4, 1, 1, 1));
        st.push_back(mk(0, 32'h0000_0000, IDLE,   1, 4'b0001, 3'd0, 1, 0, 1));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL unmapped_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL unmapped_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_unmapped_idle();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(0, 32'hF000_0000, IDLE,   1, 4'b0000, 3'd4, 1, 0, 1));
        st.push_back(mk(0, 32'hF000_0000, BUSY,   1, 4'b0000, 3'd4, 1, 0, 1));
        st.push_back(mk(0, 32'h4000_0000, IDLE,   1, 4'b0000, 3'd4, 1, 0, 1));
        st.push_back(mk(0, 32'h1FFF_FFFF, IDLE,   1, 4'b0010, 3'd1, 1, 0, 1));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL idle_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(1, 32'h0000_0000, IDLE,   1, 4'b0001, 3'd4, 1, 0, 0));
        st.push_back(mk(0, 32'h8000_0000, NONSEQ, 1, 4'b0000, 3'd4, 0, 1, 1));
        st.push_back(mk(0, 32'h8000_0000, NONSEQ, 0, 4'b0000, 3'd4, 1, 1, 1));
        st.push_back(mk(0, 32'h8000_0000, NONSEQ, 1, 4'b0000, 3'd4, 0, 1, 2));
        st.push_back(mk(0, 32'h0000_0000, IDLE,   0, 4'b0001, 3'd4, 1, 1, 2));
        st.push_back(mk(0, 32'h0000_0000, IDLE,   1, 4'b0001, 3'd0, 1, 0, 2));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL b2b_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_wait_hold();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(0, 32'h2000_0000, NONSEQ, 1, 4'b0100, 3'd2, 1, 0, 2));
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk(0, 32'h8000_0000, NONSEQ, 0, 4'b0000, 3'd2, 1, 0, 2));
        end
        st.push_back(mk(0, 32'h0000_0000, IDLE,   1, 4'b0001, 3'd0, 1, 0, 2));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL wait_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wait_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_error();
        stim_t st[$];
        obs_t  e;
        obs_t  o;
        st.push_back(mk(0, 32'h5000_0000, NONSEQ, 1, 4'b0000, 3'd4, 0, 1, 3));
        st.push_back(mk(1, 32'h1000_0000, NONSEQ, 1, 4'b0010, 3'd4, 1, 0, 0));
        st.push_back(mk(0, 32'h0000_0000, IDLE,   1, 4'b0001, 3'd0, 1, 0, 0));
        foreach (st[k]) begin
            HRESET = st[k].rst; HADDR = st[k].addr; HTRANS = st[k].trans; HREADY = st[k].ready;
            #1;
            checks++;
            if (HSEL !== st[k].hsel) begin
                errors++;
                $display("FAIL rstmid_hsel[%0d]: got %b expected %b", k, HSEL, st[k].hsel);
            end
            sb.push_back(st[k].exp);
            @(posedge HCLK); @(negedge HCLK);
            e = sb.pop_front();
            o = {MUX_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_resp[%0d]: got sel=%0d rdy=%b resp=%b cnt=%0d expected sel=%0d rdy=%b resp=%b cnt=%0d",
                         k, o.sel, o.rdy, o.resp, o.cnt, e.sel, e.rdy, e.resp, e.cnt);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        HRESET = 1'b1;
        HADDR  = 32'h0;
        HTRANS = IDLE;
        HREADY = 1'b1;
        @(negedge HCLK);
        test_reset();
        test_sweep();
        test_unmapped();
        test_unmapped_idle();
        test_back_to_back();
        test_wait_hold();
        test_reset_mid_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
